// File: rtl/rvfi_dmem_multi_check.sv
// Shadows NWORDS monitored data-memory words across NRET retirement channels.
// Mismatches go to registered, sticky error outputs.
module rvfi_dmem_multi_check #(
    parameter int XLEN       = 32,
    parameter int NRET       = 1,
    parameter int NWORDS     = 2,
    parameter int READ_LEARN = 0,
    parameter int CNT_W      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NWORDS*XLEN-1:0]                 mon_addr,
    input  logic [NRET-1:0]                        rvfi_valid,
    input  logic [NRET*64-1:0]                     rvfi_order,
    input  logic [NRET-1:0]                        rvfi_trap,
    input  logic [NRET*XLEN-1:0]                   rvfi_mem_addr,
    input  logic [NRET*(XLEN/8)-1:0]               rvfi_mem_rmask,
    input  logic [NRET*(XLEN/8)-1:0]               rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]                   rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]                   rvfi_mem_wdata,
    output logic [NWORDS*(XLEN/8)-1:0]             known,
    output logic                                   err,
    output logic [63:0]                            err_order,
    output logic [(NRET > 1 ? $clog2(NRET) : 1)-1:0]     err_chan,
    output logic [(NWORDS > 1 ? $clog2(NWORDS) : 1)-1:0] err_word,
    output logic [XLEN/8-1:0]                      err_bmask,
    output logic [CNT_W-1:0]                       err_count
);

    localparam int NB     = XLEN / 8;
    localparam int LSB    = $clog2(NB);
    localparam int CHAN_W = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [XLEN-1:0]  ADDR_MASK = {XLEN{1'b1}} << LSB;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [NWORDS*XLEN-1:0] mon_q;
    logic [NWORDS*XLEN-1:0] shadow_q, shadow_d;
    logic [NWORDS*NB-1:0]   known_q, known_d;
    logic                   err_q, err_d;
    logic [63:0]            err_order_q, err_order_d;
    logic [CHAN_W-1:0]      err_chan_q, err_chan_d;
    logic [WORD_W-1:0]      err_word_q, err_word_d;
    logic [NB-1:0]          err_bmask_q, err_bmask_d;
    logic [CNT_W-1:0]       err_count_q, err_count_d;

    logic [NB-1:0]          bm;
    logic                   found;
    int unsigned            ev_cnt;
    int unsigned            sum;
    int                     idx;

    // Program-order walk: shadow_d/known_d are the working copy, so a write on
    // an earlier channel is seen by reads on later channels of the same cycle.
    always_comb begin
        shadow_d    = shadow_q;
        known_d     = known_q;
        err_order_d = err_order_q;
        err_chan_d  = err_chan_q;
        err_word_d  = err_word_q;
        err_bmask_d = err_bmask_q;
        bm          = '0;
        found       = 1'b0;
        ev_cnt      = 0;
        sum         = 0;
        idx         = 0;
        for (int c = 0; c < NRET; c++) begin
            for (int w = 0; w < NWORDS; w++) begin
                bm = '0;
                if (rvfi_valid[c] && !rvfi_trap[c] &&
                    (((rvfi_mem_addr[c*XLEN +: XLEN] ^ mon_q[w*XLEN +: XLEN]) & ADDR_MASK) == '0)) begin
                    for (int b = 0; b < NB; b++) begin
                        idx = w*NB + b;
                        if (rvfi_mem_rmask[c*NB + b]) begin
                            if (known_d[idx]) begin
                                if (rvfi_mem_rdata[c*XLEN + b*8 +: 8] != shadow_d[idx*8 +: 8])
                                    bm[b] = 1'b1;
                            end else if (READ_LEARN != 0) begin
                                shadow_d[idx*8 +: 8] = rvfi_mem_rdata[c*XLEN + b*8 +: 8];
                                known_d[idx]         = 1'b1;
                            end
                        end
                        if (rvfi_mem_wmask[c*NB + b]) begin
                            shadow_d[idx*8 +: 8] = rvfi_mem_wdata[c*XLEN + b*8 +: 8];
                            known_d[idx]         = 1'b1;
                        end
                    end
                end
                if (bm != '0) begin
                    ev_cnt = ev_cnt + 1;
                    if (!err_q && !found) begin
                        found       = 1'b1;
                        err_order_d = rvfi_order[c*64 +: 64];
                        err_chan_d  = CHAN_W'(c);
                        err_word_d  = WORD_W'(w);
                        err_bmask_d = bm;
                    end
                end
            end
        end
        err_d = err_q | (ev_cnt != 0);
        sum   = 32'(err_count_q) + ev_cnt;
        if (sum > 32'(CNT_MAX))
            err_count_d = CNT_MAX;
        else
            err_count_d = CNT_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mon_q       <= mon_addr;
            shadow_q    <= '0;
            known_q     <= '0;
            err_q       <= 1'b0;
            err_order_q <= '0;
            err_chan_q  <= '0;
            err_word_q  <= '0;
            err_bmask_q <= '0;
            err_count_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            known_q     <= known_d;
            err_q       <= err_d;
            err_order_q <= err_order_d;
            err_chan_q  <= err_chan_d;
            err_word_q  <= err_word_d;
            err_bmask_q <= err_bmask_d;
            err_count_q <= err_count_d;
        end
    end

    assign known     = known_q;
    assign err       = err_q;
    assign err_order = err_order_q;
    assign err_chan  = err_chan_q;
    assign err_word  = err_word_q;
    assign err_bmask = err_bmask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Bench for rvfi_dmem_multi_check: two instances (READ_LEARN=0 and 1) on shared
// two-channel stimulus, checked against a byte-array memory model.
module tb_rvfi_dmem_multi_check;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  mon_addr;
    logic [1:0]   valid, trap;
    logic [127:0] order;
    logic [63:0]  addr, rdata, wdata;
    logic [7:0]   rmask, wmask;

    logic [1:0][7:0]  known_w;
    logic [1:0]       err_w;
    logic [1:0][63:0] err_order_w;
    logic [1:0]       err_chan_w;
    logic [1:0]       err_word_w;
    logic [1:0][3:0]  err_bmask_w;
    logic [1:0][7:0]  err_count_w;

    // model state, indexed [instance][word][byte]
    logic [31:0] m_mon[2];
    logic [7:0]  m_data[2][2][4];
    bit          m_known[2][2][4];
    bit          m_err[2];
    logic [63:0] m_order[2];
    int          m_chan[2], m_word[2], m_count[2];
    logic [3:0]  m_bmask[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .NWORDS(2), .READ_LEARN(0), .CNT_W(8)) dut_nolearn (
        .clk(clk), .reset(reset), .mon_addr(mon_addr),
        .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap),
        .rvfi_mem_addr(addr), .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
        .rvfi_mem_rdata(rdata), .rvfi_mem_wdata(wdata),
        .known(known_w[0]), .err(err_w[0]), .err_order(err_order_w[0]),
        .err_chan(err_chan_w[0:0]), .err_word(err_word_w[0:0]),
        .err_bmask(err_bmask_w[0]), .err_count(err_count_w[0]));

    rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .NWORDS(2), .READ_LEARN(1), .CNT_W(8)) dut_learn (
        .clk(clk), .reset(reset), .mon_addr(mon_addr),
        .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap),
        .rvfi_mem_addr(addr), .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
        .rvfi_mem_rdata(rdata), .rvfi_mem_wdata(wdata),
        .known(known_w[1]), .err(err_w[1]), .err_order(err_order_w[1]),
        .err_chan(err_chan_w[1:1]), .err_word(err_word_w[1:1]),
        .err_bmask(err_bmask_w[1]), .err_count(err_count_w[1]));

    // ---------------- model ----------------
    task automatic model_step();
        logic [31:0] a;
        logic [3:0]  bad;
        logic [7:0]  rb;
        int          ev;
        bit          found;
        if (reset) begin
            m_mon[0] = mon_addr[31:0];
            m_mon[1] = mon_addr[63:32];
        end
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int w = 0; w < 2; w++)
                    for (int b = 0; b < 4; b++) begin
                        m_data[d][w][b]  = 8'h00;
                        m_known[d][w][b] = 1'b0;
                    end
                m_err[d] = 1'b0; m_order[d] = 64'd0; m_chan[d] = 0;
                m_word[d] = 0; m_bmask[d] = 4'd0; m_count[d] = 0;
            end else begin
                ev = 0;
                found = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    if (valid[c] && !trap[c]) begin
                        a = addr[c*32 +: 32];
                        for (int w = 0; w < 2; w++) begin
                            bad = 4'd0;
                            if ((a >> 2) == (m_mon[w] >> 2)) begin
                                for (int b = 0; b < 4; b++) begin
                                    rb = rdata[c*32 + b*8 +: 8];
                                    if (rmask[c*4 + b] && m_known[d][w][b] && rb != m_data[d][w][b])
                                        bad[b] = 1'b1;
                                    if (rmask[c*4 + b] && !m_known[d][w][b] && d == 1) begin
                                        m_data[d][w][b] = rb;
                                        m_known[d][w][b] = 1'b1;
                                    end
                                    if (wmask[c*4 + b]) begin
                                        m_data[d][w][b] = wdata[c*32 + b*8 +: 8];
                                        m_known[d][w][b] = 1'b1;
                                    end
                                end
                            end
                            if (bad != 4'd0) begin
                                ev++;
                                if (!m_err[d] && !found) begin
                                    found = 1'b1;
                                    m_order[d] = order[c*64 +: 64];
                                    m_chan[d] = c; m_word[d] = w; m_bmask[d] = bad;
                                end
                            end
                        end
                    end
                end
                if (ev > 0) m_err[d] = 1'b1;
                m_count[d] = (m_count[d] + ev > 255) ? 255 : m_count[d] + ev;
            end
        end
    endtask

    function automatic logic [7:0] exp_known(input int d);
        logic [7:0] k;
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++)
                k[w*4 + b] = m_known[d][w][b];
        return k;
    endfunction

    // ---------------- driver ----------------
    task automatic idle();
        reset = 1'b0; valid = '0; trap = '0; order = '0; addr = '0;
        rmask = '0; wmask = '0; rdata = '0; wdata = '0;
    endtask

    task automatic drive(input int c, input logic [31:0] a, input logic [3:0] rm,
                         input logic [31:0] rd, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [63:0] ord, input bit tr);
        valid[c] = 1'b1; trap[c] = tr; addr[c*32 +: 32] = a;
        rmask[c*4 +: 4] = rm; rdata[c*32 +: 32] = rd;
        wmask[c*4 +: 4] = wm; wdata[c*32 +: 32] = wd;
        order[c*64 +: 64] = ord;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] m0, input logic [31:0] m1);
        idle();
        reset = 1'b1;
        mon_addr = {m1, m0};
        step();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(32'h100, 32'h200);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({known_w[d], err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got known=%h err=%b order=%h chan=%b word=%b bmask=%h count=%0d want all 0",
                         d, known_w[d], err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]);
            end
        end
    endtask

    task automatic test_basic();
        idle();
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'hDEADBEEF, 64'd1, 1'b0);
        step();
        idle();
        drive(0, 32'h100, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0, 64'd2, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (known_w[d] !== 8'h0F) begin errors++; $display("FAIL basic_known dut%0d got %h want 0f", d, known_w[d]); end
            checks++;
            if (err_w[d] !== 1'b0) begin errors++; $display("FAIL basic_err dut%0d got %b want 0", d, err_w[d]); end
        end
    endtask

    task automatic test_mismatch();
        idle();
        drive(0, 32'h103, 4'hF, 32'hDEADBE00, 4'h0, 32'h0, 64'd7, 1'b0);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err_w[d] !== 1'b0) begin errors++; $display("FAIL err_early dut%0d got %b want 0", d, err_w[d]); end
        end
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]} !== {1'b1, 64'd7, 1'b0, 1'b0, 4'h1, 8'd1}) begin
                errors++;
                $display("FAIL first_error dut%0d got err=%b order=%0d chan=%b word=%b bmask=%h count=%0d want 1/7/0/0/1/1",
                         d, err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]);
            end
        end
        idle();
        drive(0, 32'h100, 4'hF, 32'h00ADBEEF, 4'h0, 32'h0, 64'd9, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err_order_w[d], err_bmask_w[d], err_count_w[d]} !== {64'd7, 4'h1, 8'd2}) begin
                errors++;
                $display("FAIL second_error dut%0d got order=%0d bmask=%h count=%0d want 7/1/2",
                         d, err_order_w[d], err_bmask_w[d], err_count_w[d]);
            end
        end
    endtask

    task automatic test_forwarding();
        do_reset(32'h100, 32'h200);
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h11223344, 64'd10, 1'b0);
        drive(1, 32'h100, 4'hF, 32'h11223344, 4'h0, 32'h0, 64'd11, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({known_w[d], err_w[d]} !== {8'h0F, 1'b0}) begin
                errors++; $display("FAIL fwd_ok dut%0d got known=%h err=%b want 0f/0", d, known_w[d], err_w[d]);
            end
        end
        idle();
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h55667788, 64'd12, 1'b0);
        drive(1, 32'h101, 4'hF, 32'h11223344, 4'h0, 32'h0, 64'd13, 1'b0);
        step();
        // read-modify-write on ch0 compares the pre-write value; ch1 sees the new one
        idle();
        drive(0, 32'h100, 4'hF, 32'h55667788, 4'hF, 32'h99AABBCC, 64'd14, 1'b0);
        drive(1, 32'h100, 4'hF, 32'h99AABBCC, 4'h0, 32'h0, 64'd15, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]} !== {1'b1, 64'd13, 1'b1, 1'b0, 4'hF, 8'd1}) begin
                errors++;
                $display("FAIL fwd_stale dut%0d got err=%b order=%0d chan=%b word=%b bmask=%h count=%0d want 1/13/1/0/f/1",
                         d, err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]);
            end
        end
    endtask

    task automatic test_learn();
        do_reset(32'h100, 32'h200);
        drive(0, 32'h200, 4'h3, 32'h0000ABCD, 4'h0, 32'h0, 64'd20, 1'b0);
        step();
        checks++;
        if ({known_w[0], err_w[0]} !== {8'h00, 1'b0}) begin errors++; $display("FAIL learn_off_known got known=%h err=%b want 00/0", known_w[0], err_w[0]); end
        checks++;
        if ({known_w[1], err_w[1]} !== {8'h30, 1'b0}) begin errors++; $display("FAIL learn_on_known got known=%h err=%b want 30/0", known_w[1], err_w[1]); end
        idle();
        drive(0, 32'h202, 4'h3, 32'h0000ABCE, 4'h0, 32'h0, 64'd21, 1'b0);
        step();
        checks++;
        if (err_w[0] !== 1'b0) begin errors++; $display("FAIL learn_off_err got %b want 0", err_w[0]); end
        checks++;
        if ({err_w[1], err_order_w[1], err_word_w[1], err_bmask_w[1]} !== {1'b1, 64'd21, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL learn_on_err got err=%b order=%0d word=%b bmask=%h want 1/21/1/1", err_w[1], err_order_w[1], err_word_w[1], err_bmask_w[1]);
        end
    endtask

    task automatic test_trap_and_reset();
        do_reset(32'h100, 32'h200);
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h00001234, 64'd30, 1'b1);
        drive(1, 32'h100, 4'h0, 32'hFFFFFFFF, 4'h0, 32'h0, 64'd31, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({known_w[d], err_w[d]} !== {8'h00, 1'b0}) begin
                errors++; $display("FAIL trap_ignored dut%0d got known=%h err=%b want 00/0", d, known_w[d], err_w[d]);
            end
        end
        idle();
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h00001234, 64'd32, 1'b0);
        step();
        idle();
        drive(0, 32'h100, 4'hF, 32'h00001235, 4'h0, 32'h0, 64'd33, 1'b0);
        step();
        idle();
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h0000FFFF, 64'd34, 1'b0);
        reset = 1'b1;
        mon_addr = {32'h300, 32'h100};
        step();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({known_w[d], err_w[d], err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d], err_count_w[d]} !== '0) begin
                errors++;
                $display("FAIL midrun_reset dut%0d got known=%h err=%b order=%h count=%0d want all 0",
                         d, known_w[d], err_w[d], err_order_w[d], err_count_w[d]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset(32'h100, 32'h100);
        drive(0, 32'h100, 4'h0, 32'h0, 4'hF, 32'h00000000, 64'd40, 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (known_w[d] !== 8'hFF) begin errors++; $display("FAIL dup_known dut%0d got %h want ff", d, known_w[d]); end
        end
        for (int i = 0; i < 65; i++) begin
            idle();
            drive(0, 32'h100, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0, 64'(100 + i), 1'b0);
            drive(1, 32'h102, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0, 64'(200 + i), 1'b0);
            step();
            if (i == 0 || i == 62 || i == 63 || i == 64) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (err_count_w[d] !== ((i == 0) ? 8'd4 : (i == 62) ? 8'd252 : 8'd255)) begin
                        errors++; $display("FAIL sat_count dut%0d cycle%0d got %0d want %0d", d, i, err_count_w[d],
                                           (i == 0) ? 4 : (i == 62) ? 252 : 255);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d]} !== {64'd100, 1'b0, 1'b0, 4'hF}) begin
                errors++;
                $display("FAIL tie_break dut%0d got order=%0d chan=%b word=%b bmask=%h want 100/0/0/f",
                         d, err_order_w[d], err_chan_w[d], err_word_w[d], err_bmask_w[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool[3];
        logic [31:0] rd;
        int          wi, sel, src;
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
        do_reset(pool[$urandom_range(0, 1)], pool[$urandom_range(0, 2)]);
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                mon_addr = {pool[$urandom_range(0, 2)], pool[$urandom_range(0, 1)]};
            end
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 3) != 0) begin
                    sel = $urandom_range(0, 4);
                    wi  = (sel < 2) ? 0 : 1;
                    src = $urandom_range(0, 1);
                    for (int b = 0; b < 4; b++) rd[b*8 +: 8] = m_data[src][wi][b];
                    if ($urandom_range(0, 7) == 0) rd = rd ^ (32'd1 << $urandom_range(0, 31));
                    drive(c, ((sel == 4) ? 32'h300 : m_mon[wi]) | 32'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), rd, 4'($urandom_range(0, 15)), $urandom,
                          {$urandom, $urandom}, $urandom_range(0, 9) == 0);
                end
            end
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (known_w[d] !== exp_known(d)) begin errors++; $display("FAIL rnd_known dut%0d n=%0d got %h want %h", d, n, known_w[d], exp_known(d)); end
                checks++;
                if (err_w[d] !== m_err[d]) begin errors++; $display("FAIL rnd_err dut%0d n=%0d got %b want %b", d, n, err_w[d], m_err[d]); end
                checks++;
                if (err_order_w[d] !== m_order[d]) begin errors++; $display("FAIL rnd_order dut%0d n=%0d got %h want %h", d, n, err_order_w[d], m_order[d]); end
                checks++;
                if ({err_chan_w[d], err_word_w[d]} !== {1'(m_chan[d]), 1'(m_word[d])}) begin
                    errors++; $display("FAIL rnd_chan_word dut%0d n=%0d got %b/%b want %0d/%0d", d, n, err_chan_w[d], err_word_w[d], m_chan[d], m_word[d]);
                end
                checks++;
                if (err_bmask_w[d] !== m_bmask[d]) begin errors++; $display("FAIL rnd_bmask dut%0d n=%0d got %h want %h", d, n, err_bmask_w[d], m_bmask[d]); end
                checks++;
                if (err_count_w[d] !== 8'(m_count[d])) begin errors++; $display("FAIL rnd_count dut%0d n=%0d got %0d want %0d", d, n, err_count_w[d], m_count[d]); end
            end
        end
    endtask

    initial begin
        idle();
        mon_addr = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_forwarding();
        test_learn();
        test_trap_and_reset();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
